// File: rtl/instr_seq.sv
// Program buffer and replay sequencer for the nn instruction port.
// The host loads {repeat, instr} entries, and run_start replays them, holding each word for repeat+1 cycles.
module instr_seq #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned REPEAT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_valid,
  output logic                     prog_ready,
  input  logic [23:0]              prog_instr,
  input  logic [REPEAT_W-1:0]      prog_repeat,
  input  logic                     prog_clear,
  output logic [$clog2(DEPTH):0]   prog_count,
  input  logic                     run_start,
  input  logic                     run_abort,
  output logic                     run_busy,
  output logic                     run_done,
  output logic [23:0]              instruction
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_count, w_count_nxt;
  logic [AW-1:0]       r_idx, w_idx_nxt;
  logic [REPEAT_W-1:0] r_rep, w_rep_nxt;
  logic [23:0]         r_instr, w_instr_nxt;

  logic [23:0]         r_mem_instr [DEPTH];
  logic [REPEAT_W-1:0] r_mem_rep   [DEPTH];

  logic                w_wr;
  logic                w_last;
  logic [AW-1:0]       w_idx_inc;
  logic [REPEAT_W-1:0] w_cur_rep;
  logic [23:0]         w_next_instr;
  logic [23:0]         w_first_instr;

  assign prog_ready    = (r_state == IDLE) && (r_count < CW'(DEPTH)) && !prog_clear;
  assign w_wr          = prog_valid && prog_ready;
  assign w_idx_inc     = r_idx + AW'(1);
  assign w_cur_rep     = r_mem_rep[r_idx];
  assign w_next_instr  = r_mem_instr[w_idx_inc];
  assign w_first_instr = r_mem_instr[AW'(0)];
  assign w_last        = ({1'b0, r_idx} == (r_count - CW'(1)));

  // Storage has no reset: entries beyond prog_count are never read.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_instr[r_count[AW-1:0]] <= prog_instr;
      r_mem_rep[r_count[AW-1:0]]   <= prog_repeat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_rep   <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_idx   <= w_idx_nxt;
      r_rep   <= w_rep_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_rep_nxt   = r_rep;
    w_instr_nxt = r_instr;
    case (r_state)
      IDLE: begin
        if (prog_clear) begin
          w_count_nxt = '0;
        end else if (w_wr) begin
          w_count_nxt = r_count + CW'(1);
        end
        // run_start sees the pre-write count, and a same-cycle run_abort has no effect here.
        if (run_start) begin
          if (r_count != '0) begin
            w_state_nxt = RUN;
            w_idx_nxt   = '0;
            w_rep_nxt   = '0;
            w_instr_nxt = w_first_instr;
          end else begin
            w_state_nxt = DONE;
            w_instr_nxt = '0;
          end
        end
      end
      RUN: begin
        if (run_abort) begin
          w_state_nxt = IDLE;
          w_instr_nxt = '0;
        end else if (r_rep == w_cur_rep) begin
          if (w_last) begin
            w_state_nxt = DONE;
            w_instr_nxt = '0;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_rep_nxt   = '0;
            w_instr_nxt = w_next_instr;
          end
        end else begin
          w_rep_nxt = r_rep + REPEAT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_instr_nxt = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_instr_nxt = '0;
      end
    endcase
  end

  assign prog_count  = r_count;
  assign run_busy    = (r_state == RUN);
  assign run_done    = (r_state == DONE);
  assign instruction = r_instr;

endmodule

// File: tb/tb_instr_seq.sv
// Directed self-checking bench for instr_seq: load, replay, abort, clear, full buffer and reset cases.
module tb_instr_seq;

  logic        clk;
  logic        rst;
  logic        prog_valid;
  logic        prog_ready;
  logic [23:0] prog_instr;
  logic [7:0]  prog_repeat;
  logic        prog_clear;
  logic [4:0]  prog_count;
  logic        run_start;
  logic        run_abort;
  logic        run_busy;
  logic        run_done;
  logic [23:0] instruction;

  int checks = 0;
  int errors = 0;
  int n;

  instr_seq #(.DEPTH(16), .REPEAT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_valid  (prog_valid),
    .prog_ready  (prog_ready),
    .prog_instr  (prog_instr),
    .prog_repeat (prog_repeat),
    .prog_clear  (prog_clear),
    .prog_count  (prog_count),
    .run_start   (run_start),
    .run_abort   (run_abort),
    .run_busy    (run_busy),
    .run_done    (run_done),
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; prog_valid = 1'b0; prog_instr = '0; prog_repeat = '0;
    prog_clear = 1'b0; run_start = 1'b0; run_abort = 1'b0;
    repeat (2) tick();
    chk("rst_count", 32'(prog_count), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_busy", 32'(run_busy), 0);
    chk("rst_done", 32'(run_done), 0);
    chk("rst_ready", 32'(prog_ready), 1);
    rst = 1'b0;
    tick();

    // two entries, basic replay
    prog_valid = 1'b1; prog_instr = 24'h000101; prog_repeat = 8'd0;
    tick();
    prog_instr = 24'h0000A2; prog_repeat = 8'd2;
    tick();
    prog_valid = 1'b0;
    chk("load2_count", 32'(prog_count), 2);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    chk("b_t1_instr", 32'(instruction), 32'h000101);
    chk("b_t1_busy", 32'(run_busy), 1);
    tick();
    chk("b_t2_instr", 32'(instruction), 32'h0000A2);
    prog_valid = 1'b1; prog_instr = 24'h00EEEE;
    #1;
    chk("run_ready", 32'(prog_ready), 0);
    tick();
    prog_valid = 1'b0;
    chk("b_t3_instr", 32'(instruction), 32'h0000A2);
    tick();
    chk("b_t4_instr", 32'(instruction), 32'h0000A2);
    chk("b_t4_done", 32'(run_done), 0);
    tick();
    chk("b_t5_instr", 32'(instruction), 0);
    chk("b_t5_done", 32'(run_done), 1);
    chk("b_t5_busy", 32'(run_busy), 0);
    tick();
    chk("b_t6_done", 32'(run_done), 0);
    chk("b_t6_ready", 32'(prog_ready), 1);
    chk("b_t6_count", 32'(prog_count), 2);

    // second replay, with run_start held into RUN (ignored there)
    run_start = 1'b1;
    tick();
    chk("r2_t1_instr", 32'(instruction), 32'h000101);
    tick();
    run_start = 1'b0;
    chk("r2_t2_instr", 32'(instruction), 32'h0000A2);
    repeat (2) tick();
    chk("r2_t4_instr", 32'(instruction), 32'h0000A2);
    tick();
    chk("r2_t5_done", 32'(run_done), 1);
    tick();

    // clear with a same-cycle write, then an empty replay
    prog_clear = 1'b1; prog_valid = 1'b1; prog_instr = 24'hFFFFFF; prog_repeat = 8'd0;
    #1;
    chk("clr_ready", 32'(prog_ready), 0);
    tick();
    prog_clear = 1'b0; prog_valid = 1'b0;
    chk("clr_count", 32'(prog_count), 0);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    chk("empty_done", 32'(run_done), 1);
    chk("empty_instr", 32'(instruction), 0);
    chk("empty_busy", 32'(run_busy), 0);
    tick();
    chk("empty_done2", 32'(run_done), 0);
    chk("empty_busy2", 32'(run_busy), 0);

    // abort on the third RUN cycle
    prog_valid = 1'b1; prog_instr = 24'h0000C5; prog_repeat = 8'd5;
    tick();
    prog_instr = 24'h0000C6; prog_repeat = 8'd0;
    tick();
    prog_valid = 1'b0;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    chk("ab_c1_instr", 32'(instruction), 32'h0000C5);
    tick();
    run_abort = 1'b1;
    chk("ab_c3_pre", 32'(instruction), 32'h0000C5);
    tick();
    run_abort = 1'b0;
    chk("ab_instr", 32'(instruction), 0);
    chk("ab_busy", 32'(run_busy), 0);
    chk("ab_done", 32'(run_done), 0);
    tick();
    chk("ab_done2", 32'(run_done), 0);
    // start and abort together in IDLE: start wins, replay from entry 0
    run_start = 1'b1; run_abort = 1'b1;
    tick();
    run_start = 1'b0; run_abort = 1'b0;
    chk("sa_c1_instr", 32'(instruction), 32'h0000C5);
    chk("sa_c1_busy", 32'(run_busy), 1);
    repeat (5) tick();
    chk("sa_c6_instr", 32'(instruction), 32'h0000C5);
    tick();
    chk("sa_c7_instr", 32'(instruction), 32'h0000C6);
    tick();
    chk("sa_c8_done", 32'(run_done), 1);
    tick();

    // overfill: 19 offered writes, only 16 stored
    prog_clear = 1'b1;
    tick();
    prog_clear = 1'b0;
    for (int i = 0; i < 19; i++) begin
      prog_valid = 1'b1; prog_instr = 24'h000100 + 24'(i); prog_repeat = 8'd0;
      tick();
    end
    prog_valid = 1'b0;
    chk("full_count", 32'(prog_count), 16);
    chk("full_ready", 32'(prog_ready), 0);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_e%0d", i), 32'(instruction), 32'h100 + 32'(i));
      tick();
    end
    chk("full_done", 32'(run_done), 1);
    tick();

    // asynchronous reset in the middle of a replay
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    repeat (2) tick();
    chk("mr_pre_instr", 32'(instruction), 32'h000102);
    #2 rst = 1'b1;
    #1;
    chk("mr_instr", 32'(instruction), 0);
    chk("mr_count", 32'(prog_count), 0);
    chk("mr_busy", 32'(run_busy), 0);
    chk("mr_ready", 32'(prog_ready), 1);
    #1 rst = 1'b0;
    prog_valid = 1'b1; prog_instr = 24'h00ABCD; prog_repeat = 8'd0;
    tick();
    prog_valid = 1'b0;
    chk("post_rst_count", 32'(prog_count), 1);

    // maximum repeat value
    prog_clear = 1'b1;
    tick();
    prog_clear = 1'b0;
    prog_valid = 1'b1; prog_instr = 24'hABCDEF; prog_repeat = 8'd255;
    tick();
    prog_valid = 1'b0;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    n = 0;
    while (instruction === 24'hABCDEF && n < 300) begin
      n++;
      tick();
    end
    chk("max_rep_cycles", 32'(n), 256);
    chk("max_rep_done", 32'(run_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
